// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file controller: FSM states and the
// per-port read-data source selection.
package regfile_ctrl_pkg;

  // Controller phase: INIT zero-fills the RAM, RUN serves the core.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Source of a read port's output data.
  typedef enum logic [1:0] {
    ZERO = 2'd0,  // address 0 (hard-wired zero) or post-reset state
    BYP  = 2'd1,  // same-cycle write forwarded from the bypass register
    RAM  = 2'd2   // registered RAM read data
  } rd_sel_t;

  localparam int unsigned NUM_RD_PORTS = 2;

  // Decide where a read port's next output comes from.
  function automatic rd_sel_t rd_select(input logic addr_is_zero,
                                        input logic write_hit);
    rd_sel_t sel;
    if (addr_is_zero) begin
      sel = ZERO;
    end else if (write_hit) begin
      sel = BYP;
    end else begin
      sel = RAM;
    end
    return sel;
  endfunction

endpackage : regfile_ctrl_pkg

// File: rtl/regfile_ctrl.sv
// Register-file controller sitting in front of a 2-read/1-write BRAM.
// After reset it zero-fills every RAM entry, then passes core requests to
// the RAM, keeps address 0 reading as zero and forwards same-cycle writes
// to the read ports (write-first at the core interface).
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DTW = 32,
  parameter int unsigned DPT = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  output logic                     o_ready,
  // core write request
  input  logic                     i_wren,
  input  logic [$clog2(DPT)-1:0]   i_waddr,
  input  logic [DTW-1:0]           i_wdata,
  // core read request / data
  input  logic                     i_rden,
  input  logic [$clog2(DPT)-1:0]   i_raddr0,
  input  logic [$clog2(DPT)-1:0]   i_raddr1,
  output logic [DTW-1:0]           o_rdata0,
  output logic [DTW-1:0]           o_rdata1,
  // RAM write port
  output logic                     o_ram_wren,
  output logic [$clog2(DPT)-1:0]   o_ram_waddr,
  output logic [DTW-1:0]           o_ram_wdata,
  // RAM read ports
  output logic                     o_ram_rden,
  output logic [$clog2(DPT)-1:0]   o_ram_raddr0,
  output logic [$clog2(DPT)-1:0]   o_ram_raddr1,
  input  logic [DTW-1:0]           i_ram_rdata0,
  input  logic [DTW-1:0]           i_ram_rdata1
);

  localparam int unsigned ADW    = $clog2(DPT);
  localparam int unsigned DPT_2N = 2 ** ADW;

  state_t           state_q;
  state_t           state_d;
  logic [ADW-1:0]   sweep_q;
  logic             run;
  logic             capture;
  logic             wr_valid;
  logic [DTW-1:0]   byp_q;

  logic [ADW-1:0]   raddr     [NUM_RD_PORTS];
  logic [DTW-1:0]   ram_rdata [NUM_RD_PORTS];
  logic [DTW-1:0]   rdata     [NUM_RD_PORTS];

  assign raddr[0]     = i_raddr0;
  assign raddr[1]     = i_raddr1;
  assign ram_rdata[0] = i_ram_rdata0;
  assign ram_rdata[1] = i_ram_rdata1;
  assign o_rdata0     = rdata[0];
  assign o_rdata1     = rdata[1];

  // FSM state register; reset always restarts the zero-fill sweep.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweep address counter, advancing one entry per cycle while in INIT.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sweep_q <= '0;
    end else if (state_q == INIT) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  // Next-state logic: leave INIT once the last entry (all-ones address,
  // i.e. DPT_2N-1) has been written.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (sweep_q == ADW'(DPT_2N - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Output logic: RAM port muxing between the sweep and the core.
  // The sweep write enable is qualified with aresetn so the RAM sees no
  // write while reset is held; the first sweep write lands on the first
  // edge after release, giving ready exactly DPT_2N cycles later.
  always_comb begin
    run          = 1'b0;
    o_ready      = 1'b0;
    o_ram_wren   = 1'b0;
    o_ram_waddr  = i_waddr;
    o_ram_wdata  = i_wdata;
    o_ram_rden   = 1'b0;
    o_ram_raddr0 = i_raddr0;
    o_ram_raddr1 = i_raddr1;
    unique case (state_q)
      INIT: begin
        o_ram_wren  = aresetn;
        o_ram_waddr = sweep_q;
        o_ram_wdata = '0;
      end
      RUN: begin
        run        = 1'b1;
        o_ready    = 1'b1;
        o_ram_wren = i_wren && (i_waddr != '0);
        o_ram_rden = i_rden;
      end
      default: ;
    endcase
  end

  assign capture  = run && i_rden;
  assign wr_valid = i_wren && (i_waddr != '0);

  // Bypass data register, loaded with the write data on every accepted read.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      byp_q <= '0;
    end else if (capture) begin
      byp_q <= i_wdata;
    end
  end

  for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rd_port
    rd_sel_t        sel_q;
    rd_sel_t        sel_d;
    logic [DTW-1:0] out;

    assign sel_d = rd_select(raddr[gp] == '0,
                             wr_valid && (i_waddr == raddr[gp]));

    // Read-source select register, updated only on accepted reads so the
    // output holds (zero, bypass or RAM) between reads.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        sel_q <= ZERO;
      end else if (capture) begin
        sel_q <= sel_d;
      end
    end

    // Read data mux; forced to zero until the sweep has completed.
    always_comb begin
      out = '0;
      if (run) begin
        unique case (sel_q)
          BYP:     out = byp_q;
          RAM:     out = ram_rdata[gp];
          default: out = '0;
        endcase
      end
    end

    assign rdata[gp] = out;
  end

endmodule : regfile_ctrl

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with a behavioural dual-read BRAM
// beside it and a register-file reference model (write-first, entry 0 = 0).
module tb_regfile_ctrl;

  localparam int unsigned DTW = 32;
  localparam int unsigned DPT = 32;
  localparam int unsigned AW  = 5;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic            o_ready;
  logic            i_wren = 1'b0;
  logic [AW-1:0]   i_waddr = '0;
  logic [DTW-1:0]  i_wdata = '0;
  logic            i_rden = 1'b0;
  logic [AW-1:0]   i_raddr0 = '0;
  logic [AW-1:0]   i_raddr1 = '0;
  logic [DTW-1:0]  o_rdata0;
  logic [DTW-1:0]  o_rdata1;
  logic            o_ram_wren;
  logic [AW-1:0]   o_ram_waddr;
  logic [DTW-1:0]  o_ram_wdata;
  logic            o_ram_rden;
  logic [AW-1:0]   o_ram_raddr0;
  logic [AW-1:0]   o_ram_raddr1;
  logic [DTW-1:0]  ram_q0;
  logic [DTW-1:0]  ram_q1;

  // RAM model: registered read (old data on collision), synchronous write.
  logic [DTW-1:0]  mem [DPT];

  // Reference model state.
  logic [DTW-1:0]  ref_mem [DPT];
  logic [DTW-1:0]  exp0;
  logic [DTW-1:0]  exp1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(.DTW(DTW), .DPT(DPT)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .o_ready      (o_ready),
    .i_wren       (i_wren),
    .i_waddr      (i_waddr),
    .i_wdata      (i_wdata),
    .i_rden       (i_rden),
    .i_raddr0     (i_raddr0),
    .i_raddr1     (i_raddr1),
    .o_rdata0     (o_rdata0),
    .o_rdata1     (o_rdata1),
    .o_ram_wren   (o_ram_wren),
    .o_ram_waddr  (o_ram_waddr),
    .o_ram_wdata  (o_ram_wdata),
    .o_ram_rden   (o_ram_rden),
    .o_ram_raddr0 (o_ram_raddr0),
    .o_ram_raddr1 (o_ram_raddr1),
    .i_ram_rdata0 (ram_q0),
    .i_ram_rdata1 (ram_q1)
  );

  always @(posedge clk) begin
    if (o_ram_rden) begin
      ram_q0 <= mem[o_ram_raddr0];
      ram_q1 <= mem[o_ram_raddr1];
    end
    if (o_ram_wren) mem[o_ram_waddr] <= o_ram_wdata;
  end

  task automatic check(input string tag, input logic [DTW-1:0] got,
                       input logic [DTW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < int'(DPT); a++) ref_mem[a] = '0;
    exp0 = '0;
    exp1 = '0;
  endtask

  // Assert reset at the current time and check the immediate effect.
  task automatic hit_reset();
    aresetn = 1'b0;
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_wren",  32'(o_ram_wren), 32'd0);
    check("rst_rden",  32'(o_ram_rden), 32'd0);
    check("rst_rd0",   o_rdata0, '0);
    check("rst_rd1",   o_rdata1, '0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  // Walk n sweep cycles starting right after release, with random core
  // traffic that must be ignored. A full sweep also checks ready and RAM.
  task automatic sweep_check(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      i_wren   = 1'($urandom);
      i_waddr  = AW'($urandom);
      i_wdata  = $urandom;
      i_rden   = 1'($urandom);
      i_raddr0 = AW'($urandom);
      i_raddr1 = AW'($urandom);
      #1;
      check("sw_wren",  32'(o_ram_wren), 32'd1);
      check("sw_waddr", 32'(o_ram_waddr), i);
      check("sw_wdata", o_ram_wdata, '0);
      check("sw_rden",  32'(o_ram_rden), 32'd0);
      check("sw_ready", 32'(o_ready), 32'd0);
      check("sw_rd0",   o_rdata0, '0);
      check("sw_rd1",   o_rdata1, '0);
      @(negedge clk);
    end
    i_wren = 1'b0;
    i_rden = 1'b0;
    if (n == DPT) begin
      #1;
      check("ready_up", 32'(o_ready), 32'd1);
      for (int a = 0; a < int'(DPT); a++) check("ram_zero", mem[a], '0);
      @(negedge clk);
    end
  endtask

  // One RUN cycle, entered and left on a falling edge.
  task automatic step(input logic wren, input logic [AW-1:0] wa,
                      input logic [DTW-1:0] wd, input logic rden,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    i_wren = wren; i_waddr = wa; i_wdata = wd;
    i_rden = rden; i_raddr0 = ra0; i_raddr1 = ra1;
    #1;
    check("run_ready", 32'(o_ready), 32'd1);
    check("ram_wren",  32'(o_ram_wren), 32'(wren && wa != 0));
    check("ram_rden",  32'(o_ram_rden), 32'(rden));
    if (rden) check("ram_raddr", {o_ram_raddr1, o_ram_raddr0}, {ra1, ra0});
    // Register file semantics: write-first, entry 0 reads zero.
    if (wren && wa != 0) ref_mem[wa] = wd;
    if (rden) begin
      exp0 = ref_mem[ra0];
      exp1 = ref_mem[ra1];
    end
    @(posedge clk);
    #1;
    check("rdata0", o_rdata0, exp0);
    check("rdata1", o_rdata1, exp1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] wa, ra0, ra1;
    for (int a = 0; a < int'(DPT); a++) mem[a] = $urandom | 32'h1;
    ram_q0 = $urandom;
    ram_q1 = $urandom;
    clear_model();

    #3;
    hit_reset();
    sweep_check(DPT);

    // Plain write then read.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0);
    // Collision on both ports.
    step(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7);
    check("ram7", mem[7], 32'h12345678);
    // Address 0 is never written and always reads zero.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    check("ram0", mem[0], '0);
    // Held read data survives a later write to the same entry.
    step(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd7);
    for (int k = 0; k < 3; k++) step(1'b1, 5'd9, 32'h0, 1'b0, 5'd9, 5'd9);
    // Held bypass result after a collision.
    step(1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd1, 5'd3);
    step(1'b1, 5'd3, 32'h11112222, 1'b0, 5'd3, 5'd3);

    // Random traffic, biased towards a few addresses and collisions.
    for (int n = 0; n < 400; n++) begin
      wa  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      step(1'($urandom), wa, $urandom, ($urandom_range(0, 3) != 0), ra0, ra1);
    end
    for (int a = 0; a < int'(DPT); a++) check("ram_final", mem[a], ref_mem[a]);

    // Reset in RUN with non-zero held data, then mid-sweep, then full sweep.
    step(1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd12, 5'd12);
    #2;
    hit_reset();
    sweep_check(12);
    #1;
    check("mid_addr", 32'(o_ram_waddr), 32'd12);
    hit_reset();
    sweep_check(DPT);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd5);
    step(1'b1, 5'd12, 32'h600DCAFE, 1'b1, 5'd12, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_regfile_ctrl

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter DTW, default 32, data width in bits.
REQ-002 SHALL have parameter DPT, default 32, entry count; derived ADW = clog2(DPT) and DPT_2N = 2**ADW, both non-overridable.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge; aresetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have o_ready  out  1  high once the init sweep is done and core access is accepted.
REQ-005 SHALL have i_wren  in  1 / i_waddr  in  ADW / i_wdata  in  DTW as the core write request.
REQ-006 SHALL have i_rden  in  1 / i_raddr0, i_raddr1  in  ADW as the core read request.
REQ-007 SHALL have o_rdata0, o_rdata1  out  DTW as the core read data, valid one cycle after i_rden.
REQ-008 SHALL have o_ram_wren  out  1 / o_ram_waddr  out  ADW / o_ram_wdata  out  DTW as the write port driving bram_dp_r2w1.
REQ-009 SHALL have o_ram_rden  out  1 / o_ram_raddr0, o_ram_raddr1  out  ADW / i_ram_rdata0, i_ram_rdata1  in  DTW as the read ports to bram_dp_r2w1.

Function
REQ-010 SHALL implement FSM states INIT and RUN; reset entry is INIT.
REQ-011 INIT: SHALL drive o_ram_wren=1, o_ram_wdata=0 and o_ram_waddr = sweep counter, counting 0 to DPT_2N-1 at one address per cycle.
REQ-012 INIT: SHALL move to RUN in the cycle after address DPT_2N-1 is written; o_ready rises in the first RUN cycle, exactly DPT_2N cycles after reset deassertion.
REQ-013 INIT: SHALL ignore core writes, force o_ram_rden=0, and force o_rdata0/1 to 0.
REQ-014 RUN: SHALL pass i_rden, i_raddr0 and i_raddr1 combinationally to the RAM read port.
REQ-015 RUN: SHALL pass i_wren, i_waddr and i_wdata combinationally to the RAM write port, except that o_ram_wren=0 when i_waddr==0.
REQ-016 Read latency SHALL be exactly 1 cycle, matching the RAM's registered read.
REQ-017 Address 0 SHALL read as 0 on both ports regardless of RAM contents.
REQ-018 Collision: when i_rden=1, i_wren=1, i_waddr!=0 and i_waddr==i_raddrN in the same cycle, o_rdataN on the next cycle SHALL equal i_wdata (write-first at the core interface).
REQ-019 The bypass SHALL work independently per port; both ports may hit the same write at once.
REQ-020 A per-port select register SHALL capture {zero, bypass, ram} and a DTW bypass register SHALL capture i_wdata, both only when i_rden=1.
REQ-021 When i_rden=0, o_rdataN SHALL hold its previous value, including a held bypass or zero result.
REQ-022 A later write to the same address SHALL NOT alter held read data.
REQ-023 Core requests SHALL always be accepted in RUN (no backpressure); o_ready is the only flow signal.

Reset
REQ-024 When aresetn=0 (asynchronous), the block SHALL enter INIT with sweep counter=0, o_ready=0, read select=zero (o_rdata0/1=0) and bypass register=0.
REQ-025 During reset, o_ram_wren and o_ram_rden SHALL be 0; the sweep starts on the first clk edge after release.
REQ-026 Reset asserted mid-sweep or in RUN SHALL restart the full sweep from address 0.

Structure
REQ-027 The FSM state enum (INIT, RUN) and the read-select enum (ZERO, BYP, RAM) SHALL live in the shared core package.
REQ-028 No sub-module SHALL be instantiated; bram_dp_r2w1 is instantiated beside this block by the parent, and the per-port select logic is replicated with a generate loop.

Verification (DPT=32, DTW=32)
REQ-029 Release reset -> o_ram_wren=1 for 32 cycles with waddr 0..31 and wdata=0, then o_ready=1 on cycle 32; RAM fully zero.
REQ-030 RUN: write addr 5 = 0xDEADBEEF, next cycle read raddr0=5 -> o_rdata0=0xDEADBEEF one cycle later.
REQ-031 Same cycle: write addr 7 = 0x12345678 and read raddr0=7, raddr1=7 -> both outputs = 0x12345678 next cycle; RAM addr 7 holds 0x12345678 afterwards.
REQ-032 Write addr 0 = 0xFFFFFFFF -> o_ram_wren stays 0; reading addr 0 returns 0x00000000, including a same-cycle collision.
REQ-033 Read addr 9 (value 0xA5A5A5A5), then i_rden=0 for 3 cycles while addr 9 is written with 0x0 -> o_rdata0 holds 0xA5A5A5A5 throughout.
REQ-034 Assert aresetn=0 at sweep address 12 (or in RUN) -> o_ready=0 and outputs=0 immediately; after release the sweep restarts at address 0 and takes 32 cycles.
